// File: rtl/control_unit_if.sv
// Control-strobe bundle between control_unit (master) and CPU_datapath (slave).
// Optional CU_SINGLE_STEP_EN adds the step input used by the single-step PAUSE state.
interface control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
`ifdef CU_SINGLE_STEP_EN
    logic        step;
`endif
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout, Yout;
    logic Baout, Rout_in, GRA, GRB, GRC;
    logic PCin, IRin, MARin, MDRin, Yin, ZIn, HIin, LOin, R_enableIn, enableCon, enableOutPort;
    logic IncPC, Read, RAMrd, RAMin;
    logic [4:0] alu_op;
    logic run, illegal;

    modport master (
        input  ir, con_ff, stop,
`ifdef CU_SINGLE_STEP_EN
               step,
`endif
        output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout, Yout,
               Baout, Rout_in, GRA, GRB, GRC,
               PCin, IRin, MARin, MDRin, Yin, ZIn, HIin, LOin, R_enableIn, enableCon, enableOutPort,
               IncPC, Read, RAMrd, RAMin, alu_op, run, illegal
    );

    modport slave (
        output ir, con_ff, stop,
`ifdef CU_SINGLE_STEP_EN
               step,
`endif
        input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout, Yout,
               Baout, Rout_in, GRA, GRB, GRC,
               PCin, IRin, MARin, MDRin, Yin, ZIn, HIin, LOin, R_enableIn, enableCon, enableOutPort,
               IncPC, Read, RAMrd, RAMin, alu_op, run, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for CPU_datapath: fetch T0-T2, per-opcode execute T3-T7.
// Optional macro CU_SINGLE_STEP_EN adds a PAUSE state released by the step input.
module control_unit #(
    parameter int OPW     = 5,
    parameter int ST_BITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);
    localparam logic [ST_BITS-1:0] S_RESET = 4'd0;
    localparam logic [ST_BITS-1:0] S_T0    = 4'd1;
    localparam logic [ST_BITS-1:0] S_T1    = 4'd2;
    localparam logic [ST_BITS-1:0] S_T2    = 4'd3;
    localparam logic [ST_BITS-1:0] S_T3    = 4'd4;
    localparam logic [ST_BITS-1:0] S_T4    = 4'd5;
    localparam logic [ST_BITS-1:0] S_T5    = 4'd6;
    localparam logic [ST_BITS-1:0] S_T6    = 4'd7;
    localparam logic [ST_BITS-1:0] S_T7    = 4'd8;
    localparam logic [ST_BITS-1:0] S_HALT  = 4'd9;
    localparam logic [ST_BITS-1:0] S_PAUSE = 4'd10;
    localparam logic [OPW-1:0]     OP_ADD  = 5'b00011;

    logic [ST_BITS-1:0] state_reg, state_next, last_state, done_state;
    logic               illegal_reg;
    logic [OPW-1:0]     op;
    logic [2**OPW-1:0]  op_hot;
    logic               unused_ir;

    assign op        = bus.ir[31 -: OPW];
    assign unused_ir = ^bus.ir[31-OPW:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2**OPW; gi++) begin : g_op_dec
            assign op_hot[gi] = (op == OPW'(gi));
        end
    endgenerate

    logic is_ld, is_ldi, is_st, is_mem, is_rtype, is_imm, is_muldiv, is_unary;
    logic is_br, is_jr, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt, is_illegal;

    assign is_ld      = op_hot[0];
    assign is_ldi     = op_hot[1];
    assign is_st      = op_hot[2];
    assign is_mem     = |op_hot[2:0];
    assign is_rtype   = |op_hot[11:3];
    assign is_imm     = |op_hot[14:12];
    assign is_muldiv  = |op_hot[16:15];
    assign is_unary   = |op_hot[18:17];
    assign is_br      = op_hot[19];
    assign is_jr      = op_hot[20];
    assign is_in      = op_hot[22];
    assign is_out     = op_hot[23];
    assign is_mfhi    = op_hot[24];
    assign is_mflo    = op_hot[25];
    assign is_nop     = op_hot[26];
    assign is_halt    = op_hot[27];
    assign is_illegal = op_hot[21] | (|op_hot[31:28]);

    // Final execute state for each instruction class; T3 covers the single-cycle ops.
    always_comb begin
        last_state = S_T3;
        if (is_ld || is_st)
            last_state = S_T7;
        else if (is_muldiv || is_br)
            last_state = S_T6;
        else if (is_ldi || is_rtype || is_imm)
            last_state = S_T5;
        else if (is_unary)
            last_state = S_T4;
    end

`ifdef CU_SINGLE_STEP_EN
    assign done_state = S_PAUSE;
`else
    assign done_state = S_T0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2: begin
                if (is_illegal || is_halt) state_next = S_HALT;
                else if (is_nop)           state_next = S_T0;
                else                       state_next = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_reg == last_state)
                    state_next = bus.stop ? S_HALT : done_state;
                else
                    state_next = state_reg + {{(ST_BITS-1){1'b0}}, 1'b1};
            end
            S_HALT:  state_next = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: state_next = bus.step ? S_T0 : S_PAUSE;
`endif
            default: state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_RESET;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_T2 && is_illegal)
                illegal_reg <= 1'b1;
        end
    end

    always_comb begin
        {bus.PCout, bus.MDRout, bus.Zhighout, bus.Zlowout, bus.HIout, bus.LOout,
         bus.InPortout, bus.Cout, bus.Yout} = '0;
        {bus.Baout, bus.Rout_in, bus.GRA, bus.GRB, bus.GRC} = '0;
        {bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.ZIn, bus.HIin, bus.LOin,
         bus.R_enableIn, bus.enableCon, bus.enableOutPort} = '0;
        {bus.IncPC, bus.Read, bus.RAMrd, bus.RAMin} = '0;
        bus.alu_op  = '0;
        bus.run     = (state_reg >= S_T0) && (state_reg <= S_T7);
        bus.illegal = illegal_reg;
        if (state_reg >= S_T3 && state_reg <= S_T7)
            bus.alu_op = (is_mem || op_hot[12] || is_br) ? OP_ADD : op;
        case (state_reg)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; end
            S_T1: begin bus.Read = 1'b1; bus.RAMrd = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                if (is_mem)                begin bus.GRB = 1'b1; bus.Baout = 1'b1; bus.Yin = 1'b1; end
                if (is_rtype || is_imm)    begin bus.GRB = 1'b1; bus.Rout_in = 1'b1; bus.Yin = 1'b1; end
                if (is_muldiv)             begin bus.GRA = 1'b1; bus.Rout_in = 1'b1; bus.Yin = 1'b1; end
                if (is_unary)              begin bus.GRB = 1'b1; bus.Rout_in = 1'b1; bus.ZIn = 1'b1; end
                if (is_br)                 begin bus.GRA = 1'b1; bus.Rout_in = 1'b1; bus.enableCon = 1'b1; end
                if (is_jr)                 begin bus.GRA = 1'b1; bus.Rout_in = 1'b1; bus.PCin = 1'b1; end
                if (is_in)                 begin bus.InPortout = 1'b1; bus.GRA = 1'b1; bus.R_enableIn = 1'b1; end
                if (is_out)                begin bus.GRA = 1'b1; bus.Rout_in = 1'b1; bus.enableOutPort = 1'b1; end
                if (is_mfhi || is_mflo)    begin bus.GRA = 1'b1; bus.R_enableIn = 1'b1; end
                bus.HIout = is_mfhi;
                bus.LOout = is_mflo;
            end
            S_T4: begin
                if (is_mem || is_imm)      begin bus.Cout = 1'b1; bus.ZIn = 1'b1; end
                if (is_rtype)              begin bus.GRC = 1'b1; bus.Rout_in = 1'b1; bus.ZIn = 1'b1; end
                if (is_muldiv)             begin bus.GRB = 1'b1; bus.Rout_in = 1'b1; bus.ZIn = 1'b1; end
                if (is_unary)              begin bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.R_enableIn = 1'b1; end
                if (is_br)                 begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
            end
            S_T5: begin
                if (is_ld || is_st)        begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                if (is_ldi || is_rtype || is_imm)
                                           begin bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.R_enableIn = 1'b1; end
                if (is_muldiv)             begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                if (is_br)                 begin bus.Cout = 1'b1; bus.ZIn = 1'b1; end
            end
            S_T6: begin
                if (is_ld)                 begin bus.Read = 1'b1; bus.RAMrd = 1'b1; bus.MDRin = 1'b1; end
                if (is_st)                 begin bus.GRA = 1'b1; bus.Rout_in = 1'b1; bus.MDRin = 1'b1; end
                if (is_muldiv)             begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                // Branch target is committed only when the CON flip-flop says so.
                if (is_br)                 begin bus.Zlowout = 1'b1; bus.PCin = bus.con_ff; end
            end
            S_T7: begin
                if (is_ld)                 begin bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.R_enableIn = 1'b1; end
                if (is_st)                 bus.RAMin = 1'b1;
            end
            default: ;
        endcase
    end

    assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.PCout, bus.MDRout, bus.Zhighout, bus.Zlowout, bus.HIout, bus.LOout,
                  bus.InPortout, bus.Cout, bus.Yout, bus.Baout, bus.Rout_in}));
endmodule
